// File: rtl/spi_register_controller.sv
// Bridges one SPI command word per frame onto a single-master req/ack register bus.
// Responses are returned one frame later. Tracks ack timeouts, aborted frames and overruns.
module spi_register_controller #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                     system_clk,
  input  logic                     system_rst_n,
  input  logic                     spi_cs_stop,
  input  logic                     spi_value_valid,
  input  logic [ADDR_W+DATA_W:0]   spi_value_mosi,
  output logic [ADDR_W+DATA_W:0]   spi_value_miso,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic                     bus_ack,
  input  logic [DATA_W-1:0]        bus_rdata,
  output logic [7:0]               frame_errors,
  output logic [7:0]               overruns
);

  localparam int WIDTH = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_OVERRUN = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_FRAME   = 2'b11;

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  assign bus_req = (state == REQ);

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      spi_value_miso <= '0;
      frame_errors   <= '0;
      overruns       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (spi_value_valid) begin
            bus_we    <= spi_value_mosi[WIDTH-1];
            bus_addr  <= spi_value_mosi[WIDTH-2:DATA_W];
            bus_wdata <= spi_value_mosi[DATA_W-1:0];
            wait_cnt  <= '0;
            state     <= REQ;
          end else if (spi_cs_stop) begin
            spi_value_miso <= {ST_FRAME, {(ADDR_W-1){1'b0}}, {DATA_W{1'b0}}};
          end
        end
        default: begin
          // Completion and timeout are assigned after the overrun status so they take priority
          if (spi_value_valid)
            spi_value_miso <= {ST_OVERRUN, {(ADDR_W-1){1'b0}}, {DATA_W{1'b0}}};
          if (bus_ack) begin
            spi_value_miso <= {ST_OK, {(ADDR_W-1){1'b0}}, (bus_we ? bus_wdata : bus_rdata)};
            state          <= IDLE;
          end else if (wait_cnt == TO_LAST) begin
            spi_value_miso <= {ST_TIMEOUT, {(ADDR_W-1){1'b0}}, {DATA_W{1'b0}}};
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
      endcase

      if (spi_value_valid && (state == REQ) && (overruns != 8'hFF))
        overruns <= overruns + 8'd1;
      if (spi_cs_stop && !spi_value_valid && (frame_errors != 8'hFF))
        frame_errors <= frame_errors + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_register_controller.sv
// Randomised and directed checks of spi_register_controller against a frame-level reference model.
module tb_spi_register_controller;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        cs_stop;
  logic        valid;
  logic [31:0] mosi;
  logic [31:0] miso;
  logic        bus_req;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [23:0] bus_wdata;
  logic        bus_ack;
  logic [23:0] bus_rdata;
  logic [7:0]  frame_errors;
  logic [7:0]  overruns;

  int tests_run = 0;
  int fails = 0;

  // reference model
  bit          m_busy;
  bit          m_we;
  logic [6:0]  m_addr;
  logic [23:0] m_wdata;
  int          m_waited;
  logic [31:0] m_resp;
  int          m_fe;
  int          m_ov;

  spi_register_controller #(.ADDR_W(7), .DATA_W(24), .TIMEOUT(TO)) dut (
    .system_clk      (clk),
    .system_rst_n    (rst_n),
    .spi_cs_stop     (cs_stop),
    .spi_value_valid (valid),
    .spi_value_mosi  (mosi),
    .spi_value_miso  (miso),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata),
    .frame_errors    (frame_errors),
    .overruns        (overruns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_waited = 0; m_resp = '0; m_fe = 0; m_ov = 0;
  endtask

  // One system clock of protocol rules: a frame either starts a transfer, is dropped
  // as an overrun, or is an abort; a pending transfer ends on ack or after TO cycles.
  task automatic model_step(input bit v, input bit s, input logic [31:0] m,
                            input bit a, input logic [23:0] rd);
    if (s && !v && m_fe < 255) m_fe++;
    if (!m_busy) begin
      if (v) begin
        m_busy = 1; m_we = m[31]; m_addr = m[30:24]; m_wdata = m[23:0]; m_waited = 0;
      end else if (s) begin
        m_resp = 32'hC000_0000;
      end
    end else begin
      if (v) begin
        if (m_ov < 255) m_ov++;
        m_resp = 32'h4000_0000;
      end
      if (a) begin
        m_resp = {8'h00, (m_we ? m_wdata : rd)};
        m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin
          m_resp = 32'h8000_0000;
          m_busy = 0;
        end
      end
    end
  endtask

  // Called at a negedge: applies inputs for one rising edge, returns at the next negedge.
  task automatic tick(input bit v, input bit s, input logic [31:0] m,
                      input bit a, input logic [23:0] rd);
    valid = v; cs_stop = s; mosi = m; bus_ack = a; bus_rdata = rd;
    @(posedge clk);
    model_step(v, s, m, a, rd);
    @(negedge clk);
    valid = 0; cs_stop = 0; bus_ack = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 7'h0 || bus_wdata !== 24'h0) begin
      fails++; $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h required all 0", bus_req, bus_we, bus_addr, bus_wdata);
    end
    tests_run++;
    if (miso !== 32'h0 || frame_errors !== 8'h0 || overruns !== 8'h0) begin
      fails++; $display("FAIL reset_regs: miso=%h fe=%0d ov=%0d required 0", miso, frame_errors, overruns);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    tick(1, 1, 32'h8A00_0123, 0, '0);
    tests_run++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 7'h0A || bus_wdata !== 24'h000123) begin
      fails++; $display("FAIL write_issue: req=%b we=%b addr=%h wdata=%h required 1 1 0a 000123", bus_req, bus_we, bus_addr, bus_wdata);
    end
    tick(0, 0, '0, 0, '0);
    tick(0, 0, '0, 0, '0);
    tests_run++;
    if (bus_req !== 1'b1) begin
      fails++; $display("FAIL write_hold: req=%b required 1", bus_req);
    end
    tick(0, 0, '0, 1, 24'h777777);
    tests_run++;
    if (bus_req !== 1'b0 || miso !== 32'h0000_0123) begin
      fails++; $display("FAIL write_resp: req=%b miso=%h required 0 00000123", bus_req, miso);
    end
    tick(1, 1, 32'h0A00_0000, 0, '0);
    tests_run++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 7'h0A) begin
      fails++; $display("FAIL read_issue: req=%b we=%b addr=%h required 1 0 0a", bus_req, bus_we, bus_addr);
    end
    tick(0, 0, '0, 1, 24'hABCDEF);
    tests_run++;
    if (miso !== 32'h00AB_CDEF) begin
      fails++; $display("FAIL read_resp: miso=%h required 00abcdef", miso);
    end
  endtask

  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    tick(1, 1, {1'b0, 7'h05, 24'($urandom)}, 0, '0);
    for (int i = 0; i < 20 && bus_req === 1'b1; i++) begin
      high_cycles++;
      tick(0, 0, '0, 0, '0);
    end
    tests_run++;
    if (high_cycles != TO) begin
      fails++; $display("FAIL timeout_len: req high %0d cycles required %0d", high_cycles, TO);
    end
    tests_run++;
    if (miso !== 32'h8000_0000) begin
      fails++; $display("FAIL timeout_resp: miso=%h required 80000000", miso);
    end
    tick(0, 0, '0, 0, '0);
    tick(0, 0, '0, 1, 24'($urandom));
    tests_run++;
    if (miso !== 32'h8000_0000 || bus_req !== 1'b0) begin
      fails++; $display("FAIL late_ack: miso=%h req=%b required 80000000 0", miso, bus_req);
    end
  endtask

  task automatic test_overrun();
    logic [6:0] a1;
    logic [6:0] a2;
    a1 = 7'($urandom);
    a2 = a1 ^ 7'h55;
    tick(1, 1, {1'b0, a1, 24'h0}, 0, '0);
    tick(1, 1, {1'b1, a2, 24'($urandom)}, 0, '0);
    tests_run++;
    if (overruns !== 8'd1 || miso !== 32'h4000_0000) begin
      fails++; $display("FAIL overrun_flag: ov=%0d miso=%h required 1 40000000", overruns, miso);
    end
    tests_run++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== a1) begin
      fails++; $display("FAIL overrun_hold: req=%b we=%b addr=%h required 1 0 %h", bus_req, bus_we, bus_addr, a1);
    end
    tick(0, 0, '0, 1, 24'h000055);
    tests_run++;
    if (miso !== 32'h0000_0055) begin
      fails++; $display("FAIL overrun_complete: miso=%h required 00000055", miso);
    end
    tick(0, 0, '0, 0, '0);
    tests_run++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL overrun_dropped: req=%b required 0", bus_req);
    end
  endtask

  task automatic test_coincident();
    logic [23:0] d;
    d = 24'($urandom);
    tick(1, 1, {1'b1, 7'h11, d}, 0, '0);
    tick(1, 1, {1'b0, 7'h22, 24'h0}, 1, 24'($urandom));
    tests_run++;
    if (miso !== {8'h00, d} || overruns !== 8'd2 || bus_req !== 1'b0) begin
      fails++; $display("FAIL coincident: miso=%h ov=%0d req=%b required %h 2 0", miso, overruns, bus_req, {8'h00, d});
    end
    tick(0, 0, '0, 0, '0);
    tests_run++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL coincident_idle: req=%b required 0", bus_req);
    end
  endtask

  task automatic test_abort();
    tick(0, 1, 32'($urandom), 0, '0);
    tests_run++;
    if (frame_errors !== 8'd1 || miso !== 32'hC000_0000 || bus_req !== 1'b0) begin
      fails++; $display("FAIL abort: fe=%0d miso=%h req=%b required 1 c0000000 0", frame_errors, miso, bus_req);
    end
    for (int i = 0; i < 299; i++) tick(0, 1, '0, 0, '0);
    tests_run++;
    if (frame_errors !== 8'd255 || overruns !== 8'd2) begin
      fails++; $display("FAIL abort_saturate: fe=%0d ov=%0d required 255 2", frame_errors, overruns);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] d;
    tick(1, 1, {1'b0, 7'h33, 24'h0}, 0, '0);
    tests_run++;
    if (bus_req !== 1'b1) begin
      fails++; $display("FAIL reset_mid_pre: req=%b required 1", bus_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_req !== 1'b0 || miso !== 32'h0 || frame_errors !== 8'h0 || overruns !== 8'h0) begin
      fails++; $display("FAIL reset_mid: req=%b miso=%h fe=%0d ov=%0d required 0", bus_req, miso, frame_errors, overruns);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    d = 24'($urandom);
    tick(1, 1, {1'b1, 7'h44, d}, 0, '0);
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 7'h44 || bus_wdata !== d) begin
      fails++; $display("FAIL reset_resume_issue: req=%b addr=%h wdata=%h required 1 44 %h", bus_req, bus_addr, bus_wdata, d);
    end
    tick(0, 0, '0, 1, '0);
    tests_run++;
    if (miso !== {8'h00, d}) begin
      fails++; $display("FAIL reset_resume_resp: miso=%h required %h", miso, {8'h00, d});
    end
  endtask

  task automatic test_random();
    bit v;
    bit s;
    bit a;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0);
      s = v ? 1'b1 : ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 2) == 0);
      tick(v, s, 32'($urandom), a, 24'($urandom));
      tests_run++;
      if (bus_req !== m_busy || (m_busy && (bus_we !== m_we || bus_addr !== m_addr || bus_wdata !== m_wdata))) begin
        fails++; $display("FAIL rand_bus[%0d]: req=%b we=%b addr=%h wdata=%h required %b %b %h %h", i, bus_req, bus_we, bus_addr, bus_wdata, m_busy, m_we, m_addr, m_wdata);
      end
      tests_run++;
      if (miso !== m_resp || frame_errors !== 8'(m_fe) || overruns !== 8'(m_ov)) begin
        fails++; $display("FAIL rand_resp[%0d]: miso=%h fe=%0d ov=%0d required %h %0d %0d", i, miso, frame_errors, overruns, m_resp, m_fe, m_ov);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 0; cs_stop = 0; mosi = '0; bus_ack = 0; bus_rdata = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_timeout();
    test_overrun();
    test_coincident();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/spi_register_controller.md
Name: spi_register_controller

Overview:
- Sequences a 32-bit CPOL=0/CPHA=0 SPI slave word port into a single-master register bus.
- Each SPI frame carries one command word: a read or write of one register. The controller issues it on the bus with a req/ack handshake.
- The result is presented as the MISO word of the next frame, so responses are pipelined by one frame.
- Adds an ack timeout, frame-error counting and overrun detection.

Parameters:
- ADDR_W, 7: register address width.
- DATA_W, 24: register data width.
- TIMEOUT, 255: max cycles bus_req may stay high without bus_ack; must be ≥1.
- WIDTH, derived localparam = 1+ADDR_W+DATA_W (32 at defaults): SPI word width; must match the slave.

Ports:
- system_clk  in  1  system clock; all logic on rising edge.
- system_rst_n  in  1  asynchronous, active-low reset.
- spi_cs_stop  in  1  one-cycle pulse: chip-select released.
- spi_value_valid  in  1  one-cycle pulse, coincident with spi_cs_stop, when all WIDTH bits were received.
- spi_value_mosi  in  WIDTH  word received from master.
- spi_value_miso  out  WIDTH  response word; the slave copies it at chip-select start.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  register address.
- bus_wdata  out  DATA_W  write data.
- bus_ack  in  1  one-cycle completion strobe.
- bus_rdata  in  DATA_W  read data, valid when bus_ack=1.
- frame_errors  out  8  saturating count of aborted frames.
- overruns  out  8  saturating count of dropped commands.

Behaviour:
- Command word fields:
  - [WIDTH-1] = write flag.
  - [WIDTH-2:DATA_W] = address.
  - [DATA_W-1:0] = write data, ignored for reads.
- Response word fields:
  - [WIDTH-1:WIDTH-2] = status: 00 OK, 01 OVERRUN, 10 TIMEOUT, 11 FRAME_ERR.
  - [WIDTH-3:DATA_W] = 0.
  - [DATA_W-1:0] = data.
- Reset state (asynchronous, applied immediately):
  - FSM = IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata = 0.
  - spi_value_miso = 0 (status OK, data 0).
  - frame_errors, overruns, timeout counter = 0.
  - Reset asserted mid-transaction drops bus_req at once; the pending command is discarded.
- FSM states are IDLE and REQ.
- IDLE + spi_value_valid:
  - Latch bus_we/bus_addr/bus_wdata from spi_value_mosi.
  - bus_req = 1 from the next cycle (registered; 1-cycle latency).
  - Go to REQ.
- REQ:
  - req/we/addr/wdata are held stable.
  - The timeout counter increments each cycle while bus_ack = 0.
- REQ + bus_ack:
  - bus_req = 0 the next cycle; go to IDLE.
  - Read: response = {00, 0, bus_rdata}.
  - Write: response = {00, 0, written data}.
- Timeout: in REQ, when the counter reaches TIMEOUT with no ack:
  - bus_req = 0; go to IDLE.
  - Response = {10, 0, 0}.
  - Counter clears on entry to REQ.
- bus_ack in IDLE: ignored, no state change.
- spi_value_valid while in REQ (including the same cycle as bus_ack):
  - Command dropped; overruns increments (saturating at 255).
  - Response status = 01, data = 0.
  - A later completion or timeout of the in-flight command overwrites the response.
  - If ack and valid coincide, the ack completion writes the response and wins.
- spi_cs_stop without spi_value_valid:
  - frame_errors increments (saturating).
  - If in IDLE: response = {11, 0, 0}.
  - If in REQ: only the counter changes.
  - No bus activity either way.
- The response register changes only on the events above.
- spi_value_miso is a registered output, stable between events.
- The SPI side never stalls; there is at most one outstanding bus transaction.

Test Plan:
- Write then read-back:
  - Frame 0x8A000123 (write addr 0x0A, data 0x000123); ack after 3 cycles → bus_req high 1 cycle after valid, bus_we = 1, addr 0x0A, wdata 0x000123.
  - Next frame's response = 0x00000123.
  - Read frame 0x0A000000 with bus_rdata = 0xABCDEF → response 0x00ABCDEF.
- Timeout: TIMEOUT = 4, read command, no ack → bus_req high for exactly 4 cycles then low; response 0x80000000; a late ack 2 cycles after is ignored.
- Overrun: second valid frame arrives while first is in REQ → overruns = 1, response 0x40000000. After ack with rdata 0x000055, response = 0x00000055. Second command never appears on the bus.
- Coincident ack and valid in the same cycle → completion response written, overruns += 1, FSM returns to IDLE with no new req.
- Aborted frame: cs_stop without valid in IDLE → frame_errors = 1, response 0xC0000000, no bus_req. Drive 300 aborts → frame_errors saturates at 255.
- Reset mid-REQ: assert system_rst_n = 0 while bus_req = 1 → bus_req, spi_value_miso and counters go to 0 without a clock edge. After release, a new frame is serviced normally.
